// File: rtl/cbx_param_cfgchain_pkg.sv
// Shared constants and elaboration-time helpers for the X-channel connection
// block: defaults for the fabric geometry, clog2, tap placement and derivation
// of the per-pin configuration word widths.
package cb_cfg_pkg;

    localparam int CHAN_W_DEF     = 11;
    localparam int NUM_IPIN_DEF   = 8;
    localparam int TAPS_DEF       = 3;
    localparam int TAP_STRIDE_DEF = 5;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Track feeding tap k of pin j; taps spread by stride and wrap around the channel.
    function automatic int tap_track(input int j, input int k, input int stride, input int w);
        return (j + k * stride) % w;
    endfunction

    // Select field width for a mux that sees a left and right copy of each tap.
    function automatic int sel_width(input int taps);
        return clog2(2 * taps);
    endfunction

    // Per-pin configuration word: enable bit above the select field.
    function automatic int cfg_width(input int taps);
        return sel_width(taps) + 1;
    endfunction

endpackage

// File: rtl/cbx_param_cfgchain_if.sv
// Bundle of the config-chain and routing-channel signals of the connection block.
// master = the surrounding fabric/driver, slave = the connection block itself.
interface cbx_param_cfgchain_if #(
    parameter int CHAN_W   = 11,
    parameter int NUM_IPIN = 8
);
    logic                ccff_en;
    logic                ccff_head;
    logic                ccff_tail;
    logic                cfg_done;
    logic                cfg_err;
    logic [CHAN_W-1:0]   chanx_left_in;
    logic [CHAN_W-1:0]   chanx_right_in;
    logic [CHAN_W-1:0]   chanx_left_out;
    logic [CHAN_W-1:0]   chanx_right_out;
    logic [NUM_IPIN-1:0] ipin_out;

    modport master (
        output ccff_en, ccff_head, chanx_left_in, chanx_right_in,
        input  ccff_tail, cfg_done, cfg_err, chanx_left_out, chanx_right_out, ipin_out
    );

    modport slave (
        input  ccff_en, ccff_head, chanx_left_in, chanx_right_in,
        output ccff_tail, cfg_done, cfg_err, chanx_left_out, chanx_right_out, ipin_out
    );
endinterface

// File: rtl/cbx_param_cfgchain_mux.sv
// One grid input pin: gathers its tapped tracks (left copy on even inputs,
// right copy on odd inputs), decodes the select, flags out-of-range selects
// and forces the pin low unless configuration is complete and idle.
module cb_ipin_mux
    import cb_cfg_pkg::*;
#(
    parameter  int CHAN_W     = CHAN_W_DEF,
    parameter  int TAPS       = TAPS_DEF,
    parameter  int TAP_STRIDE = TAP_STRIDE_DEF,
    parameter  int PIN_IDX    = 0,
    localparam int CFG_W      = cfg_width(TAPS)
) (
    input  logic [CHAN_W-1:0] left_in,
    input  logic [CHAN_W-1:0] right_in,
    input  logic [CFG_W-1:0]  cfg_word,
    input  logic              active,
    output logic              pin_out,
    output logic              sel_bad
);

    localparam int MUX_SIZE = 2 * TAPS;
    localparam int SEL_W    = CFG_W - 1;
    localparam logic [SEL_W:0] MUX_LIM = (SEL_W + 1)'(MUX_SIZE);

    logic [MUX_SIZE-1:0] mux_in_s;
    logic [SEL_W-1:0]    sel_s;
    logic                en_s;
    logic                in_range_s;
    logic                pick_s;
    logic                unused_s;

    assign en_s  = cfg_word[CFG_W-1];
    assign sel_s = cfg_word[SEL_W-1:0];

    // Not every pin taps every track; fold the whole channel so the rest is visibly intentional.
    assign unused_s = ^{left_in, right_in};

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        localparam int TRK = tap_track(PIN_IDX, k, TAP_STRIDE, CHAN_W);
        assign mux_in_s[2*k]   = left_in[TRK];
        assign mux_in_s[2*k+1] = right_in[TRK];
    end

    // Select decode: pick the mux input whose index equals sel (0 when none matches).
    always_comb begin
        pick_s = 1'b0;
        for (int i = 0; i < MUX_SIZE; i++) begin
            pick_s = (sel_s == SEL_W'(i)) ? mux_in_s[i] : pick_s;
        end
    end

    // Range check and output gating.
    always_comb begin
        in_range_s = ({1'b0, sel_s} < MUX_LIM);
        pin_out    = active & en_s & in_range_s & pick_s;
        sel_bad    = en_s & ~in_range_s;
    end

endmodule

// File: rtl/cbx_param_cfgchain.sv
// X-channel connection block: straight-through tracks in both directions plus
// NUM_IPIN configurable input-pin muxes programmed through a serial ccff chain.
// A saturating bit counter raises cfg_done once the whole chain has been loaded;
// pins stay low while the chain is shifting or before it is full.
module cbx_param_cfgchain
    import cb_cfg_pkg::*;
#(
    parameter int CHAN_W     = CHAN_W_DEF,
    parameter int NUM_IPIN   = NUM_IPIN_DEF,
    parameter int TAPS       = TAPS_DEF,
    parameter int TAP_STRIDE = TAP_STRIDE_DEF
) (
    input logic                 prog_clk,
    input logic                 pReset,
    cbx_param_cfgchain_if.slave bus
);

    localparam int CFG_W    = cfg_width(TAPS);
    localparam int CFG_BITS = NUM_IPIN * CFG_W;
    localparam int CNT_W    = clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] chain_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic                done_r;
    logic                err_r;
    logic                active_s;
    logic [NUM_IPIN-1:0] bad_s;
    logic [NUM_IPIN-1:0] ipin_s;

    // Bit counter next value: one step per shift, parked at the chain length.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (bus.ccff_en && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Config chain, counter, done and error flags.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            chain_r <= {CFG_BITS{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (bus.ccff_en) begin
                chain_r <= {chain_r[CFG_BITS-2:0], bus.ccff_head};
            end else begin
                chain_r <= chain_r;
            end
            cnt_r  <= cnt_nxt_s;
            done_r <= (cnt_nxt_s == CNT_MAX);
            err_r  <= done_r & (|bad_s);
        end
    end

    // Pins only follow the fabric once the chain is full and no longer shifting.
    assign active_s = done_r & ~bus.ccff_en;

    for (genvar j = 0; j < NUM_IPIN; j++) begin : g_pin
        cb_ipin_mux #(
            .CHAN_W     (CHAN_W),
            .TAPS       (TAPS),
            .TAP_STRIDE (TAP_STRIDE),
            .PIN_IDX    (j)
        ) u_mux (
            .left_in  (bus.chanx_left_in),
            .right_in (bus.chanx_right_in),
            .cfg_word (chain_r[j*CFG_W +: CFG_W]),
            .active   (active_s),
            .pin_out  (ipin_s[j]),
            .sel_bad  (bad_s[j])
        );
    end

    assign bus.ipin_out        = ipin_s;
    assign bus.ccff_tail       = chain_r[CFG_BITS-1];
    assign bus.cfg_done        = done_r;
    assign bus.cfg_err         = err_r;
    assign bus.chanx_right_out = bus.chanx_left_in;
    assign bus.chanx_left_out  = bus.chanx_right_in;

endmodule

// File: tb/tb_cbx_param_cfgchain.sv
// Directed bench for cbx_param_cfgchain with default geometry (32-bit chain).
module tb_cbx_param_cfgchain;

    logic prog_clk = 1'b0;
    logic pReset   = 1'b0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 prog_clk = ~prog_clk;

    cbx_param_cfgchain_if #(.CHAN_W(11), .NUM_IPIN(8)) bus_if ();

    cbx_param_cfgchain #(
        .CHAN_W(11), .NUM_IPIN(8), .TAPS(3), .TAP_STRIDE(5)
    ) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .bus      (bus_if)
    );

    // Shift w[hi] down to w[lo] (first bit lands deepest); leaves ccff_en high, time = edge+1.
    task automatic shift_bits(input logic [31:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            bus_if.ccff_en   = 1'b1;
            bus_if.ccff_head = w[i];
            @(posedge prog_clk);
            #1;
        end
    endtask

    task automatic idle_edge();
        bus_if.ccff_en = 1'b0;
        @(posedge prog_clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2;
        pReset = 1'b0;
        #2;
        pReset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus_if.ccff_en        = 1'b1;
        bus_if.ccff_head      = 1'b1;
        bus_if.chanx_left_in  = 11'h7FF;
        bus_if.chanx_right_in = 11'h7FF;
        #2;
        chk_cnt++; if (bus_if.ipin_out !== 8'h00) $display("FAIL rst_ipin got=%h exp=%h", bus_if.ipin_out, 8'h00); else pass_cnt++;
        chk_cnt++; if (bus_if.ccff_tail !== 1'b0) $display("FAIL rst_tail got=%b exp=0", bus_if.ccff_tail); else pass_cnt++;
        chk_cnt++; if (bus_if.cfg_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", bus_if.cfg_done); else pass_cnt++;
        chk_cnt++; if (bus_if.cfg_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", bus_if.cfg_err); else pass_cnt++;
        bus_if.ccff_en = 1'b0;
        #2;
        pReset = 1'b1;
        #1;
    endtask

    task automatic test_passthrough();
        logic [10:0] l_pat [4];
        logic [10:0] r_pat [4];
        l_pat = '{11'h5A5, 11'h000, 11'h7FF, 11'h123};
        r_pat = '{11'h2DA, 11'h7FF, 11'h001, 11'h400};
        for (int i = 0; i < 4; i++) begin
            bus_if.chanx_left_in  = l_pat[i];
            bus_if.chanx_right_in = r_pat[i];
            if (i == 2) pReset = 1'b0;
            #1;
            chk_cnt++; if (bus_if.chanx_right_out !== l_pat[i]) $display("FAIL thru_right got=%h exp=%h", bus_if.chanx_right_out, l_pat[i]); else pass_cnt++;
            chk_cnt++; if (bus_if.chanx_left_out !== r_pat[i]) $display("FAIL thru_left got=%h exp=%h", bus_if.chanx_left_out, r_pat[i]); else pass_cnt++;
        end
        pReset = 1'b1;
        #1;
    endtask

    task automatic test_program();
        bus_if.chanx_left_in  = 11'h7FF;
        bus_if.chanx_right_in = 11'h000;
        shift_bits(32'h0000_0009, 31, 1);
        chk_cnt++; if (bus_if.cfg_done !== 1'b0) $display("FAIL prog_done31 got=%b exp=0", bus_if.cfg_done); else pass_cnt++;
        shift_bits(32'h0000_0009, 0, 0);
        chk_cnt++; if (bus_if.cfg_done !== 1'b1) $display("FAIL prog_done32 got=%b exp=1", bus_if.cfg_done); else pass_cnt++;
        bus_if.ccff_en = 1'b0;
        bus_if.chanx_right_in = 11'h001;
        #1;
        chk_cnt++; if (bus_if.ipin_out !== 8'h01) $display("FAIL prog_pin0_hi got=%h exp=%h", bus_if.ipin_out, 8'h01); else pass_cnt++;
        bus_if.chanx_right_in = 11'h7FE;
        #1;
        chk_cnt++; if (bus_if.ipin_out !== 8'h00) $display("FAIL prog_pin0_lo got=%h exp=%h", bus_if.ipin_out, 8'h00); else pass_cnt++;
        bus_if.chanx_left_in  = 11'h000;
        bus_if.chanx_right_in = 11'h7FF;
        #1;
        chk_cnt++; if (bus_if.ipin_out !== 8'h01) $display("FAIL prog_pin0_all got=%h exp=%h", bus_if.ipin_out, 8'h01); else pass_cnt++;
    endtask

    task automatic test_tap_map();
        bus_if.chanx_left_in  = 11'h000;
        bus_if.chanx_right_in = 11'h000;
        shift_bits(32'h00C0_0000, 31, 0);
        bus_if.ccff_en = 1'b0;
        bus_if.chanx_left_in = 11'h010;
        #1;
        chk_cnt++; if (bus_if.ipin_out !== 8'h20) $display("FAIL tap_pin5_hi got=%h exp=%h", bus_if.ipin_out, 8'h20); else pass_cnt++;
        bus_if.chanx_left_in = 11'h7EF;
        #1;
        chk_cnt++; if (bus_if.ipin_out !== 8'h00) $display("FAIL tap_pin5_lo got=%h exp=%h", bus_if.ipin_out, 8'h00); else pass_cnt++;
        bus_if.chanx_left_in  = 11'h000;
        bus_if.chanx_right_in = 11'h7FF;
        #1;
        chk_cnt++; if (bus_if.ipin_out !== 8'h00) $display("FAIL tap_pin5_right got=%h exp=%h", bus_if.ipin_out, 8'h00); else pass_cnt++;
    endtask

    task automatic test_daisy();
        bus_if.chanx_left_in  = 11'h7FF;
        bus_if.chanx_right_in = 11'h7FF;
        shift_bits(32'h8000_0009, 31, 0);
        chk_cnt++; if (bus_if.ipin_out !== 8'h00) $display("FAIL daisy_gate got=%h exp=%h", bus_if.ipin_out, 8'h00); else pass_cnt++;
        chk_cnt++; if (bus_if.ccff_tail !== 1'b1) $display("FAIL daisy_tail32 got=%b exp=1", bus_if.ccff_tail); else pass_cnt++;
        shift_bits(32'h0000_0000, 0, 0);
        chk_cnt++; if (bus_if.ccff_tail !== 1'b0) $display("FAIL daisy_tail33 got=%b exp=0", bus_if.ccff_tail); else pass_cnt++;
        chk_cnt++; if (bus_if.cfg_done !== 1'b1) $display("FAIL daisy_done got=%b exp=1", bus_if.cfg_done); else pass_cnt++;
        bus_if.ccff_en = 1'b0;
    endtask

    task automatic test_invalid_sel();
        pulse_reset();
        bus_if.chanx_left_in  = 11'h7FF;
        bus_if.chanx_right_in = 11'h7FF;
        shift_bits(32'h0000_F000, 31, 0);
        bus_if.ccff_en = 1'b0;
        #1;
        chk_cnt++; if (bus_if.cfg_err !== 1'b0) $display("FAIL err_at_done got=%b exp=0", bus_if.cfg_err); else pass_cnt++;
        chk_cnt++; if (bus_if.ipin_out !== 8'h00) $display("FAIL err_pin3 got=%h exp=%h", bus_if.ipin_out, 8'h00); else pass_cnt++;
        idle_edge();
        chk_cnt++; if (bus_if.cfg_err !== 1'b1) $display("FAIL err_set got=%b exp=1", bus_if.cfg_err); else pass_cnt++;
        shift_bits(32'h0000_7000, 31, 0);
        idle_edge();
        chk_cnt++; if (bus_if.cfg_err !== 1'b0) $display("FAIL err_clear got=%b exp=0", bus_if.cfg_err); else pass_cnt++;
    endtask

    task automatic test_reset_async();
        bus_if.chanx_left_in  = 11'h000;
        bus_if.chanx_right_in = 11'h7FF;
        shift_bits(32'h8000_F009, 31, 0);
        idle_edge();
        chk_cnt++; if (bus_if.ipin_out !== 8'h01) $display("FAIL pre_rst_ipin got=%h exp=%h", bus_if.ipin_out, 8'h01); else pass_cnt++;
        chk_cnt++; if (bus_if.cfg_err !== 1'b1) $display("FAIL pre_rst_err got=%b exp=1", bus_if.cfg_err); else pass_cnt++;
        chk_cnt++; if (bus_if.ccff_tail !== 1'b1) $display("FAIL pre_rst_tail got=%b exp=1", bus_if.ccff_tail); else pass_cnt++;
        bus_if.ccff_en   = 1'b1;
        bus_if.ccff_head = 1'b1;
        #2;
        pReset = 1'b0;
        #1;
        chk_cnt++; if (bus_if.ipin_out !== 8'h00) $display("FAIL arst_ipin got=%h exp=%h", bus_if.ipin_out, 8'h00); else pass_cnt++;
        chk_cnt++; if (bus_if.ccff_tail !== 1'b0) $display("FAIL arst_tail got=%b exp=0", bus_if.ccff_tail); else pass_cnt++;
        chk_cnt++; if (bus_if.cfg_done !== 1'b0) $display("FAIL arst_done got=%b exp=0", bus_if.cfg_done); else pass_cnt++;
        chk_cnt++; if (bus_if.cfg_err !== 1'b0) $display("FAIL arst_err got=%b exp=0", bus_if.cfg_err); else pass_cnt++;
        bus_if.ccff_en = 1'b0;
        #1;
        pReset = 1'b1;
        #1;
    endtask

    task automatic test_partial_reset();
        bus_if.chanx_left_in  = 11'h7FF;
        bus_if.chanx_right_in = 11'h000;
        shift_bits(32'hFFFF_FFFF, 31, 15);
        chk_cnt++; if (bus_if.cfg_done !== 1'b0) $display("FAIL part_done17 got=%b exp=0", bus_if.cfg_done); else pass_cnt++;
        bus_if.ccff_en = 1'b0;
        pulse_reset();
        shift_bits(32'h0000_0009, 31, 1);
        chk_cnt++; if (bus_if.cfg_done !== 1'b0) $display("FAIL part_done31 got=%b exp=0", bus_if.cfg_done); else pass_cnt++;
        chk_cnt++; if (bus_if.ccff_tail !== 1'b0) $display("FAIL part_tail31 got=%b exp=0", bus_if.ccff_tail); else pass_cnt++;
        shift_bits(32'h0000_0009, 0, 0);
        chk_cnt++; if (bus_if.cfg_done !== 1'b1) $display("FAIL part_done32 got=%b exp=1", bus_if.cfg_done); else pass_cnt++;
        bus_if.ccff_en = 1'b0;
        bus_if.chanx_right_in = 11'h001;
        #1;
        chk_cnt++; if (bus_if.ipin_out !== 8'h01) $display("FAIL part_pin0_hi got=%h exp=%h", bus_if.ipin_out, 8'h01); else pass_cnt++;
        bus_if.chanx_right_in = 11'h000;
        #1;
        chk_cnt++; if (bus_if.ipin_out !== 8'h00) $display("FAIL part_pin0_lo got=%h exp=%h", bus_if.ipin_out, 8'h00); else pass_cnt++;
    endtask

    initial begin
        bus_if.ccff_en        = 1'b0;
        bus_if.ccff_head      = 1'b0;
        bus_if.chanx_left_in  = 11'h000;
        bus_if.chanx_right_in = 11'h000;
        test_reset();
        test_passthrough();
        test_program();
        test_tap_map();
        test_daisy();
        test_invalid_sel();
        test_reset_async();
        test_partial_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
